// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register slave.
// Response codes and read-channel state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ACCEPT,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register storage with per-byte write enables.
// Contents are exported flat, reg i at [i*DATA_WIDTH +: DATA_WIDTH].
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [IDX_WIDTH-1:0]           widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  // Out-of-range indices match no register, so the write drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (int'(widx) == i) begin
          for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wstrb[b]) begin
              mem[i][b*8 +: 8] <= wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_q[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank with registered handshakes.
// Define AXI_LITE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);

  localparam int SW = DATA_WIDTH/8;
  localparam int IW = ADDR_WIDTH-2;

`ifdef AXI_LITE_SLVERR_EN
  localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

  logic          aw_held;
  logic          w_held;
  logic [IW-1:0] aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic          commit;
  logic          w_ok;
  logic [IW-1:0] r_idx;
  logic          r_ok;
  logic [DATA_WIDTH-1:0] rd_word;
  logic          unused_lsbs;

  rd_state_t state;
  rd_state_t state_n;

  assign unused_lsbs = ^{awaddr[1:0], araddr[1:0]};
  assign commit = aw_held && w_held;
  assign w_ok   = int'(aw_idx_q) < NUM_REGS;
  assign r_idx  = araddr[ADDR_WIDTH-1:2];
  assign r_ok   = int'(r_idx) < NUM_REGS;

  // Readies pulse one cycle; blocked while a write is held or unanswered.
  always_ff @(posedge aclk) begin
    if (areset) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      awready <= awvalid && !awready && !aw_held && !bvalid;
      wready  <= wvalid && !wready && !w_held && !bvalid;
      if (awvalid && awready) begin
        aw_idx_q <= awaddr[ADDR_WIDTH-1:2];
        aw_held  <= 1'b1;
      end
      if (wvalid && wready) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
        w_held   <= 1'b1;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= w_ok ? RESP_OKAY : RESP_OOR;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  axi_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_WIDTH  (IW)
  ) u_bank (
    .clk    (aclk),
    .rst    (areset),
    .we     (commit),
    .widx   (aw_idx_q),
    .wdata  (w_data_q),
    .wstrb  (w_strb_q),
    .regs_q (regs_q)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= R_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      R_IDLE:   if (arvalid) state_n = R_ACCEPT;
      R_ACCEPT: state_n = R_DATA;
      R_DATA:   if (rready) state_n = R_IDLE;
      default:  state_n = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (state == R_ACCEPT);
    rvalid  = (state == R_DATA);
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(r_idx) == i) begin
        rd_word = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Captured at the AR handshake; same-edge writes are not yet visible.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (state == R_ACCEPT) begin
      rdata <= rd_word;
      rresp <= r_ok ? RESP_OKAY : RESP_OOR;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs.
// Build with AXI_LITE_SLVERR_EN to expect SLVERR on out-of-range.
module tb_axi_lite_slave_regs;
  import axi_lite_pkg::*;

`ifdef AXI_LITE_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic         aclk = 1'b0;
  logic         areset;
  logic [7:0]   awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [7:0]   araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [511:0] regs_q;

  logic [31:0] exp_regs [16];
  int errors = 0;
  int checks = 0;

  axi_lite_slave_regs dut (
    .aclk    (aclk),
    .areset  (areset),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .regs_q  (regs_q)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = exp_regs[i];
    return v;
  endfunction

  task automatic hs_aw_w(output logic to);
    logic ha, hw, ra, rw;
    int n;
    ha = 1'b0; hw = 1'b0; n = 0;
    while (!(ha && hw) && n < 20) begin
      @(negedge aclk);
      ra = awready; rw = wready;
      @(posedge aclk); #1;
      if (ra && awvalid) begin awvalid = 1'b0; ha = 1'b1; end
      if (rw && wvalid) begin wvalid = 1'b0; hw = 1'b1; end
      n++;
    end
    to = !(ha && hw);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic wait_aw(output logic to);
    logic r, done;
    int n;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      @(negedge aclk); r = awready;
      @(posedge aclk); #1;
      if (r) begin awvalid = 1'b0; done = 1'b1; end
      n++;
    end
    to = !done;
    awvalid = 1'b0;
  endtask

  task automatic wait_w(output logic to);
    logic r, done;
    int n;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      @(negedge aclk); r = wready;
      @(posedge aclk); #1;
      if (r) begin wvalid = 1'b0; done = 1'b1; end
      n++;
    end
    to = !done;
    wvalid = 1'b0;
  endtask

  task automatic wait_ar(output logic to);
    logic r, done;
    int n;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      @(negedge aclk); r = arready;
      @(posedge aclk); #1;
      if (r) begin arvalid = 1'b0; done = 1'b1; end
      n++;
    end
    to = !done;
    arvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output logic to);
    logic got;
    int n;
    got = 1'b0; n = 0; resp = 2'b11;
    bready = 1'b1;
    while (!got && n < 20) begin
      @(negedge aclk);
      if (bvalid) begin resp = bresp; got = 1'b1; end
      @(posedge aclk); #1;
      n++;
    end
    bready = 1'b0;
    to = !got;
  endtask

  task automatic wait_r(output logic [31:0] d,
                        output logic [1:0] resp,
                        output logic to);
    logic got;
    int n;
    got = 1'b0; n = 0; resp = 2'b11; d = '1;
    rready = 1'b1;
    while (!got && n < 20) begin
      @(negedge aclk);
      if (rvalid) begin d = rdata; resp = rresp; got = 1'b1; end
      @(posedge aclk); #1;
      n++;
    end
    rready = 1'b0;
    to = !got;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s,
                           output logic [1:0] resp, output logic to);
    logic t1, t2;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    hs_aw_w(t1);
    wait_b(resp, t2);
    to = t1 | t2;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic to);
    logic t1, t2;
    araddr = a; arvalid = 1'b1;
    wait_ar(t1);
    wait_r(d, resp, t2);
    to = t1 | t2;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic        to;
    logic        ha, hr, ra, rr;
    int          n;

    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_regs", regs_q, exp_vec());
    @(posedge aclk); #1;

    // full-word write then read back
    axi_write(8'h04, 32'hDEADBEEF, 4'hF, resp, to);
    exp_regs[1] = 32'hDEADBEEF;
    chk("t1_wr_to", to, 1'b0);
    chk("t1_bresp", resp, RESP_OKAY);
    chk("t1_regs", regs_q, exp_vec());
    axi_read(8'h04, d, resp, to);
    chk("t1_rd_to", to, 1'b0);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", resp, RESP_OKAY);

    // byte strobe, zero strobe, unaligned alias
    axi_write(8'h08, 32'h11223344, 4'hF, resp, to);
    axi_write(8'h08, 32'h0000AA00, 4'b0010, resp, to);
    exp_regs[2] = 32'h1122AA44;
    chk("t2_bresp", resp, RESP_OKAY);
    axi_read(8'h08, d, resp, to);
    chk("t2_rdata", d, 32'h1122AA44);
    axi_write(8'h08, 32'hFFFFFFFF, 4'h0, resp, to);
    chk("t2_zstrb_to", to, 1'b0);
    chk("t2_zstrb_bresp", resp, RESP_OKAY);
    chk("t2_zstrb_regs", regs_q, exp_vec());
    axi_read(8'h0B, d, resp, to);
    chk("t2_unaligned", d, 32'h1122AA44);

    // AW leads W by 3 cycles
    awaddr = 8'h0C; awvalid = 1'b1;
    wdata = 32'hCAFE0001; wstrb = 4'hF;
    wait_aw(to);
    chk("t3a_aw_to", to, 1'b0);
    repeat (3) @(posedge aclk);
    #1 wvalid = 1'b1;
    wait_w(to);
    chk("t3a_w_to", to, 1'b0);
    n = 0;
    while (!bvalid && n < 5) begin @(negedge aclk); n++; end
    chk("t3a_b_lat", n, 2);
    @(posedge aclk); #1;
    wait_b(resp, to);
    @(negedge aclk);
    chk("t3a_b_once", bvalid, 1'b0);
    exp_regs[3] = 32'hCAFE0001;
    chk("t3a_regs", regs_q, exp_vec());
    @(posedge aclk); #1;

    // W leads AW by 3 cycles
    wdata = 32'hCAFE0002; wstrb = 4'hF; wvalid = 1'b1;
    awaddr = 8'h10;
    wait_w(to);
    chk("t3b_w_to", to, 1'b0);
    repeat (3) @(posedge aclk);
    #1 awvalid = 1'b1;
    wait_aw(to);
    chk("t3b_aw_to", to, 1'b0);
    n = 0;
    while (!bvalid && n < 5) begin @(negedge aclk); n++; end
    chk("t3b_b_lat", n, 2);
    @(posedge aclk); #1;
    wait_b(resp, to);
    exp_regs[4] = 32'hCAFE0002;
    chk("t3b_regs", regs_q, exp_vec());

    // bready stalled with a second write pending
    axi_write(8'h14, 32'h55AA55AA, 4'hF, resp, to);
    exp_regs[5] = 32'h55AA55AA;
    awaddr = 8'h18; wdata = 32'h0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    hs_aw_w(to);
    wdata = 32'h12345678; awaddr = 8'h1C;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!bvalid && n < 10) begin @(negedge aclk); n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t4_bvalid_hold", bvalid, 1'b1);
      chk("t4_bresp_hold", bresp, RESP_OKAY);
      chk("t4_no_accept", {awready, wready}, 2'b00);
    end
    @(posedge aclk); #1;
    wait_b(resp, to);
    chk("t4_b1_to", to, 1'b0);
    exp_regs[6] = 32'h0;
    hs_aw_w(to);
    chk("t4_aw_w2_to", to, 1'b0);
    wait_b(resp, to);
    exp_regs[7] = 32'h12345678;
    chk("t4_regs", regs_q, exp_vec());

    // rready stalled
    araddr = 8'h1C; arvalid = 1'b1;
    wait_ar(to);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t4_rvalid_hold", rvalid, 1'b1);
      chk("t4_rdata_hold", rdata, 32'h12345678);
    end
    @(posedge aclk); #1;
    wait_r(d, resp, to);
    chk("t4_r_to", to, 1'b0);

    // out-of-range
    axi_write(8'h40, 32'hBADBAD00, 4'hF, resp, to);
    chk("t5_wr_to", to, 1'b0);
    chk("t5_bresp", resp, EXP_OOR);
    chk("t5_regs", regs_q, exp_vec());
    axi_read(8'h40, d, resp, to);
    chk("t5_rdata", d, 32'h0);
    chk("t5_rresp", resp, EXP_OOR);
    axi_read(8'hFC, d, resp, to);
    chk("t5_top_rdata", d, 32'h0);

    // reset in R_DATA with AW held
    awaddr = 8'h08; awvalid = 1'b1;
    araddr = 8'h04; arvalid = 1'b1;
    ha = 1'b0; hr = 1'b0; n = 0;
    while (!(ha && hr) && n < 20) begin
      @(negedge aclk);
      ra = awready; rr = arready;
      @(posedge aclk); #1;
      if (ra && awvalid) begin awvalid = 1'b0; ha = 1'b1; end
      if (rr && arvalid) begin arvalid = 1'b0; hr = 1'b1; end
      n++;
    end
    chk("t6_hs_to", {ha, hr}, 2'b11);
    @(negedge aclk);
    chk("t6_in_rdata", rvalid, 1'b1);
    @(posedge aclk); #1 areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    @(negedge aclk);
    chk("t6_ready", {awready, wready, arready}, 3'b000);
    chk("t6_valid", {bvalid, rvalid}, 2'b00);
    chk("t6_resp", {bresp, rresp}, 4'b0000);
    chk("t6_rdata", rdata, 32'h0);
    chk("t6_regs", regs_q, exp_vec());
    @(posedge aclk); #1;
    wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    wait_w(to);
    repeat (3) @(posedge aclk);
    #1;
    chk("t6_no_commit", regs_q, exp_vec());
    awaddr = 8'h24; awvalid = 1'b1;
    wait_aw(to);
    wait_b(resp, to);
    exp_regs[9] = 32'hFFFFFFFF;
    chk("t6_wr_to", to, 1'b0);
    chk("t6_wr_regs", regs_q, exp_vec());
    axi_write(8'h08, 32'h0A0B0C0D, 4'hF, resp, to);
    exp_regs[2] = 32'h0A0B0C0D;
    chk("t6_wr2_to", to, 1'b0);
    axi_read(8'h08, d, resp, to);
    chk("t6_rdata_after", d, 32'h0A0B0C0D);
    chk("t6_regs_after", regs_q, exp_vec());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
